// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: EX_WB bundle field positions
// and the store-drain state encoding.
package wb_pkg;

  localparam int EXWB_W   = 71;
  localparam int REGW_BIT = 70;
  localparam int MEMW_BIT = 69;
  localparam int RD_HI    = 68;
  localparam int RD_LO    = 64;
  localparam int RES_HI   = 63;
  localparam int RES_LO   = 32;
  localparam int SD_HI    = 31;
  localparam int SD_LO    = 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/write_back_stage_if.sv
// Bundle input, register-file write port, data-memory store port and
// retire counter of the write-back stage.
interface write_back_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  import wb_pkg::*;

  logic [EXWB_W-1:0] EX_WB;
  logic              stall;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [15:0]       retire_cnt;

  modport master (
    output EX_WB, mem_ack,
    input  stall, wb_we, wb_rd, wb_data, mem_req, mem_addr, mem_wdata, retire_cnt
  );

  modport slave (
    input  EX_WB, mem_ack,
    output stall, wb_we, wb_rd, wb_data, mem_req, mem_addr, mem_wdata, retire_cnt
  );
endinterface

// File: rtl/write_back_stage_store_buffer.sv
// Circular FIFO holding pending {addr, data} stores; pushes when full and
// pops when empty are ignored.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: register-file write-back, store buffering with a
// req/ack drain to data memory, back-pressure and retire counting.
module write_back_stage
  import wb_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5
) (
  input logic              clock,
  input logic              reset,
  write_back_stage_if.slave bus
);
  localparam int CW = $clog2(SB_DEPTH) + 1;

  logic              regw_s, memw_s, accept_s, push_s, pop_s, load_s;
  logic [REG_AW-1:0] rd_s;
  logic [DATA_W-1:0] res_s, sd_s;
  logic [2*DATA_W-1:0] head_s;
  logic [CW-1:0]     sb_count_s;
  logic              full_s, empty_s;
  wb_state_t         state_r, next_state_s;

  logic              wb_we_r;
  logic [REG_AW-1:0] wb_rd_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [DATA_W-1:0] mem_addr_r, mem_wdata_r;
  logic [15:0]       retire_r;

  assign regw_s   = bus.EX_WB[REGW_BIT];
  assign memw_s   = bus.EX_WB[MEMW_BIT];
  assign rd_s     = bus.EX_WB[RD_HI:RD_LO];
  assign res_s    = bus.EX_WB[RES_HI:RES_LO];
  assign sd_s     = bus.EX_WB[SD_HI:SD_LO];
  // A full buffer rejects the whole bundle, not just its store half.
  assign accept_s = ~full_s;
  assign push_s   = accept_s & memw_s;

  store_buffer #(.DEPTH(SB_DEPTH), .WIDTH(2*DATA_W)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data ({res_s, sd_s}),
    .pop       (pop_s),
    .head      (head_s),
    .count     (sb_count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Drain FSM next-state: latch head on entry to REQ, pop on ack.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          next_state_s = REQ;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          next_state_s = IDLE;
          pop_s        = 1'b1;
        end else begin
          next_state_s = REQ;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Store-port address/data, held stable for the whole request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_r  <= {DATA_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      mem_addr_r  <= head_s[2*DATA_W-1:DATA_W];
      mem_wdata_r <= head_s[DATA_W-1:0];
    end
  end

  // Register-file write port and retire counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_we_r   <= 1'b0;
      wb_rd_r   <= {REG_AW{1'b0}};
      wb_data_r <= {DATA_W{1'b0}};
      retire_r  <= 16'd0;
    end else begin
      wb_we_r <= accept_s & regw_s & (rd_s != {REG_AW{1'b0}});
      if (accept_s && regw_s) begin
        wb_rd_r   <= rd_s;
        wb_data_r <= res_s;
      end
      if (accept_s && (regw_s || memw_s)) retire_r <= retire_r + 16'd1;
    end
  end

  assign bus.stall      = full_s;
  assign bus.wb_we      = wb_we_r;
  assign bus.wb_rd      = wb_rd_r;
  assign bus.wb_data    = wb_data_r;
  assign bus.mem_req    = (state_r == REQ);
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.retire_cnt = retire_r;
endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage.
module tb_write_back_stage;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  write_back_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  write_back_stage #(.SB_DEPTH(4), .DATA_W(32), .REG_AW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [70:0] mk(input logic rw, input logic mw, input logic [4:0] rd,
                                     input logic [31:0] res, input logic [31:0] sd);
    return {rw, mw, rd, res, sd};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.EX_WB = 71'd0;
    bus.mem_ack = 1'b0;
    #15 reset = 1'b0;
    tick();
    checks++;
    if ({bus.stall, bus.wb_we, bus.mem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {bus.stall, bus.wb_we, bus.mem_req});
    end
    checks++;
    if ({bus.wb_rd, bus.wb_data, bus.mem_addr, bus.mem_wdata, bus.retire_cnt} !== 117'd0) begin
      errors++; $display("FAIL reset_data: rd=%h data=%h addr=%h wdata=%h retire=%h expected all 0",
                         bus.wb_rd, bus.wb_data, bus.mem_addr, bus.mem_wdata, bus.retire_cnt);
    end
    bus.EX_WB = mk(1'b0, 1'b1, 5'd0, 32'h300, 32'h77);
    tick();
    bus.EX_WB = 71'd0;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_pre_req: mem_req=%b expected 1", bus.mem_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mid_req: mem_req=%b expected 0", bus.mem_req);
    end
    checks++;
    if (dut.u_sb.count !== 3'd0 || bus.retire_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_mid_count: count=%0d retire=%h expected 0/0",
                         dut.u_sb.count, bus.retire_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_regwrite();
    bus.EX_WB = mk(1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 32'h0);
    tick();
    bus.EX_WB = 71'd0;
    checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd3 || bus.wb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL regwrite: we=%b rd=%0d data=%h expected 1/3/deadbeef",
                         bus.wb_we, bus.wb_rd, bus.wb_data);
    end
    tick();
    checks++;
    if (bus.wb_we !== 1'b0 || bus.retire_cnt !== 16'd1) begin
      errors++; $display("FAIL regwrite_pulse: we=%b retire=%0d expected 0/1", bus.wb_we, bus.retire_cnt);
    end
  endtask

  task automatic test_rd_zero();
    bus.EX_WB = mk(1'b1, 1'b0, 5'd0, 32'h1234, 32'h0);
    tick();
    bus.EX_WB = 71'd0;
    checks++;
    if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_data !== 32'h1234 || bus.retire_cnt !== 16'd2) begin
      errors++; $display("FAIL rd_zero: we=%b rd=%0d data=%h retire=%0d expected 0/0/1234/2",
                         bus.wb_we, bus.wb_rd, bus.wb_data, bus.retire_cnt);
    end
    tick();
  endtask

  task automatic test_store_ack();
    bus.mem_ack = 1'b1;
    bus.EX_WB = mk(1'b0, 1'b1, 5'd0, 32'h100, 32'h55);
    tick();
    bus.EX_WB = 71'd0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.wb_we !== 1'b0) begin
      errors++; $display("FAIL store_accept: req=%b we=%b expected 0/0", bus.mem_req, bus.wb_we);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h55) begin
      errors++; $display("FAIL store_req: req=%b addr=%h data=%h expected 1/100/55",
                         bus.mem_req, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL store_drop: req=%b expected 0", bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b0 || bus.retire_cnt !== 16'd3) begin
      errors++; $display("FAIL store_idle: req=%b retire=%0d expected 0/3", bus.mem_req, bus.retire_cnt);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr [5];
    int got;
    bit accepted5;
    bit pending;
    for (int i = 0; i < 5; i++) exp_addr[i] = 32'h200 + 32'(i * 4);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.EX_WB = mk(1'b0, 1'b1, 5'd0, exp_addr[i], 32'hA0 + 32'(i));
      tick();
    end
    bus.EX_WB = mk(1'b1, 1'b1, 5'd7, exp_addr[4], 32'hA4);
    checks++;
    if (bus.stall !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      errors++; $display("FAIL b2b_full: stall=%b req=%b addr=%h expected 1/1/200",
                         bus.stall, bus.mem_req, bus.mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.stall !== 1'b1 || bus.wb_we !== 1'b0 || bus.retire_cnt !== 16'd7) begin
        errors++; $display("FAIL b2b_stalled: stall=%b we=%b retire=%0d expected 1/0/7",
                           bus.stall, bus.wb_we, bus.retire_cnt);
      end
    end
    bus.mem_ack = 1'b1;
    got = 0;
    accepted5 = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (bus.mem_req === 1'b1) begin
        checks++;
        if (bus.mem_addr !== exp_addr[got] || bus.mem_wdata !== 32'hA0 + 32'(got)) begin
          errors++; $display("FAIL b2b_order[%0d]: addr=%h data=%h expected %h/%h",
                             got, bus.mem_addr, bus.mem_wdata, exp_addr[got], 32'hA0 + 32'(got));
        end
        got++;
      end
      pending = !bus.stall && !accepted5;
      tick();
      if (pending) begin
        accepted5 = 1'b1;
        bus.EX_WB = 71'd0;
        checks++;
        if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_data !== exp_addr[4]) begin
          errors++; $display("FAIL b2b_fifth_wb: we=%b rd=%0d data=%h expected 1/7/%h",
                             bus.wb_we, bus.wb_rd, bus.wb_data, exp_addr[4]);
        end
      end
    end
    checks++;
    if (got != 5 || !accepted5 || dut.u_sb.count !== 3'd0 || bus.retire_cnt !== 16'd8) begin
      errors++; $display("FAIL b2b_done: drained=%0d fifth=%0d count=%0d retire=%0d expected 5/1/0/8",
                         got, accepted5, dut.u_sb.count, bus.retire_cnt);
    end
    bus.EX_WB = 71'd0;
    bus.mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    bus.mem_ack = 1'b0;
    bus.EX_WB = mk(1'b0, 1'b1, 5'd0, 32'h400, 32'h1);
    tick();
    bus.EX_WB = mk(1'b0, 1'b1, 5'd0, 32'h404, 32'h2);
    tick();
    bus.EX_WB = 71'd0;
    tick();
    checks++;
    if (dut.u_sb.count !== 3'd2 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400) begin
      errors++; $display("FAIL pp_setup: count=%0d req=%b addr=%h expected 2/1/400",
                         dut.u_sb.count, bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack = 1'b1;
    bus.EX_WB = mk(1'b0, 1'b1, 5'd0, 32'h408, 32'h3);
    tick();
    bus.EX_WB = 71'd0;
    checks++;
    if (dut.u_sb.count !== 3'd2 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL pp_same_edge: count=%0d req=%b expected 2/0", dut.u_sb.count, bus.mem_req);
    end
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h404 || bus.mem_wdata !== 32'h2) begin
      errors++; $display("FAIL pp_second: req=%b addr=%h data=%h expected 1/404/2",
                         bus.mem_req, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h408 || bus.mem_wdata !== 32'h3) begin
      errors++; $display("FAIL pp_third: req=%b addr=%h data=%h expected 1/408/3",
                         bus.mem_req, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.mem_ack = 1'b0;
    checks++;
    if (dut.u_sb.count !== 3'd0 || bus.retire_cnt !== 16'd11) begin
      errors++; $display("FAIL pp_done: count=%0d retire=%0d expected 0/11", dut.u_sb.count, bus.retire_cnt);
    end
  endtask

  task automatic test_retire_wrap();
    int n;
    n = 0;
    bus.EX_WB = mk(1'b1, 1'b0, 5'd1, 32'hC0DE, 32'h0);
    while (bus.retire_cnt !== 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    bus.EX_WB = 71'd0;
    checks++;
    if (bus.retire_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_reach: retire=%h expected ffff after %0d cycles", bus.retire_cnt, n);
    end
    tick();
    checks++;
    if (bus.retire_cnt !== 16'hFFFF || bus.wb_we !== 1'b0) begin
      errors++; $display("FAIL wrap_bubble: retire=%h we=%b expected ffff/0", bus.retire_cnt, bus.wb_we);
    end
    bus.EX_WB = mk(1'b1, 1'b0, 5'd2, 32'h5A5A, 32'h0);
    tick();
    bus.EX_WB = 71'd0;
    checks++;
    if (bus.retire_cnt !== 16'h0000 || bus.wb_we !== 1'b1 || bus.wb_data !== 32'h5A5A) begin
      errors++; $display("FAIL wrap_zero: retire=%h we=%b data=%h expected 0000/1/5a5a",
                         bus.retire_cnt, bus.wb_we, bus.wb_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_regwrite();
    test_rd_zero();
    test_store_ack();
    test_back_to_back();
    test_push_pop();
    test_retire_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
